sm_product_collector: RTL and testbench

- Upstream stage of tmr_adder_tree in the fault-tolerant neuron datapath.
- Accepts (input, weight) pairs one per cycle in sign-magnitude fixed point, multiplies each pair, and rounds and saturates the product back to W bits.
- Collects N products into the packed operand bus that the adder tree consumes.
- Presents the full vector with a valid/ready handshake and flags any saturation.

---
 rtl/sm_fx_pkg.sv | 25 ++
 rtl/sm_fx_mul.sv | 32 +++
 rtl/sm_product_collector.sv | 158 +++++++++++++++
 tb/tb_sm_product_collector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm_fx_pkg.sv
// Shared sign-magnitude fixed-point definitions for the neuron datapath.
// Used by sm_product_collector and tmr_adder_tree.
package sm_fx_pkg;

    localparam int unsigned W       = 16;
    localparam int unsigned F       = 10;
    localparam int unsigned MAG_MAX = (1 << (W - 1)) - 1;
    localparam int unsigned ROUND_K = 1 << (F - 1);

    // Maximum register width the vote function handles in one call.
    localparam int unsigned VOTE_W  = 32;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Bitwise 2-of-3 majority vote; callers zero-extend narrower registers.
    function automatic logic [VOTE_W-1:0] maj3(input logic [VOTE_W-1:0] a,
                                               input logic [VOTE_W-1:0] b,
                                               input logic [VOTE_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sm_fx_mul.sv
// Combinational sign-magnitude fixed-point multiply.
// Rounds half away from zero, saturates the magnitude and never emits negative zero.
module sm_fx_mul #(
    parameter int unsigned W = 16,
    parameter int unsigned F = 10
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] w,
    output logic [W-1:0] result,
    output logic         sat
);

    localparam int unsigned PW = 2 * (W - 1);
    localparam logic [PW:0] RND = {{PW{1'b0}}, 1'b1} << (F - 1);

    logic [PW-1:0] prod;
    logic [PW:0]   rounded;
    logic [PW:0]   shifted;
    logic [W-2:0]  mag;

    // Magnitude product, round at the dropped fraction bits, then clamp.
    always_comb begin
        prod    = PW'(x[W-2:0]) * PW'(w[W-2:0]);
        rounded = {1'b0, prod} + RND;
        shifted = rounded >> F;
        sat     = |shifted[PW:W-1];
        mag     = sat ? {(W-1){1'b1}} : shifted[W-2:0];
        // A zero magnitude always carries a positive sign.
        result  = {(x[W-1] ^ w[W-1]) & (|mag), mag};
    end

endmodule

// File: rtl/sm_product_collector.sv
// Collects N rounded sign-magnitude products into the adder-tree operand bus.
// Optional build macro TMR_CTRL_EN triplicates the control registers (state, count,
// sat accumulator) with majority voting and a tmr_err disagreement pulse.
module sm_product_collector
    import sm_fx_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = sm_fx_pkg::W,
    parameter int unsigned I = 6,
    parameter int unsigned F = sm_fx_pkg::F
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_w,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] operand,
    output logic           out_sat,
    output logic           tmr_err
);

    localparam int unsigned CW     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CTRL_W = CW + 2;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (I + F != W) begin : g_cfg_check
        $error("sm_product_collector: I + F must equal W");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          sat_q, sat_d;

    logic [W-1:0]  prod;
    logic          prod_sat;
    logic          accept;
    logic [W-1:0]  slot_q [N];

    sm_fx_mul #(
        .W (W),
        .F (F)
    ) u_mul (
        .x      (in_x),
        .w      (in_w),
        .result (prod),
        .sat    (prod_sat)
    );

    assign accept    = in_valid && (state_q == FILL) && !clear;
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign out_sat   = sat_q;

    // Next-state logic: clear wins over both acceptance and the output handshake.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sat_d   = sat_q;
        if (clear) begin
            state_d = FILL;
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        sat_d = sat_q | prod_sat;
                        if (count_q == LAST) begin
                            state_d = FULL;
                            count_d = '0;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d = FILL;
                        sat_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = FILL;
                    count_d = '0;
                    sat_d   = 1'b0;
                end
            endcase
        end
    end

    // Product slots; left untouched after a handshake and overwritten by the next vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                slot_q[i] <= '0;
            end
        end else if (accept) begin
            slot_q[count_q] <= prod;
        end
    end

    // Pack slots in acceptance order, slot 0 in the least significant word.
    always_comb begin
        operand = '0;
        for (int i = 0; i < int'(N); i++) begin
            operand[i*W +: W] = slot_q[i];
        end
    end

`ifdef TMR_CTRL_EN
    logic [CTRL_W-1:0] ctrl_q [3];
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_v;
    logic [VOTE_W-1:0] vote_full;

    // Every copy advances from the voted value, so a single upset heals in one cycle.
    assign ctrl_d    = {state_d, count_d, sat_d};
    assign vote_full = maj3(VOTE_W'(ctrl_q[0]), VOTE_W'(ctrl_q[1]), VOTE_W'(ctrl_q[2]));
    assign ctrl_v    = vote_full[CTRL_W-1:0];
    assign state_q   = state_e'(ctrl_v[CTRL_W-1]);
    assign count_q   = ctrl_v[CW:1];
    assign sat_q     = ctrl_v[0];
    assign tmr_err   = (ctrl_q[0] != ctrl_v) || (ctrl_q[1] != ctrl_v) || (ctrl_q[2] != ctrl_v);

    // Triplicated control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                ctrl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                ctrl_q[i] <= ctrl_d;
            end
        end
    end
`else
    assign tmr_err = 1'b0;

    // Single-copy control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end
`endif

endmodule

// File: tb/tb_sm_product_collector.sv
// Self-checking bench for sm_product_collector: a per-cycle reference model plus
// hand-computed literal expectations from the directed scenarios.
module tb_sm_product_collector;

    localparam int unsigned N = 8;
    localparam int unsigned W = 16;

    logic           clk;
    logic           rst_n;
    logic           clear;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_w;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] operand;
    logic           out_sat;
    logic           tmr_err;

    int vectors = 0;
    int errors  = 0;

    sm_product_collector #(
        .N (N),
        .W (W),
        .I (6),
        .F (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operand   (operand),
        .out_sat   (out_sat),
        .tmr_err   (tmr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product by plain integer arithmetic: {sat, result}.
    function automatic logic [16:0] ref_mul(input logic [15:0] x, input logic [15:0] w);
        longint unsigned xm;
        longint unsigned wm;
        longint unsigned m;
        logic            s;
        logic            neg;
        xm  = longint'(x[14:0]);
        wm  = longint'(w[14:0]);
        m   = (xm * wm + 512) / 1024;
        s   = (m > 32767);
        if (s) m = 32767;
        neg = x[15] ^ w[15];
        if (m == 0) neg = 1'b0;
        return {s, neg, m[14:0]};
    endfunction

    // Reference model: what each slot holds, how many products collected, whether full.
    logic [W-1:0]   m_slot [N];
    int             m_cnt;
    bit             m_full;
    bit             m_sat;
    bit             exp_tmr = 1'b0;
    logic [127:0]   exp_op;
    logic [16:0]    r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) m_slot[i] = '0;
            m_cnt  = 0;
            m_full = 1'b0;
            m_sat  = 1'b0;
        end else if (clear) begin
            m_cnt  = 0;
            m_full = 1'b0;
            m_sat  = 1'b0;
        end else if (!m_full) begin
            if (in_valid) begin
                r = ref_mul(in_x, in_w);
                m_slot[m_cnt] = r[15:0];
                m_sat = m_sat | r[16];
                m_cnt++;
                if (m_cnt == int'(N)) begin
                    m_full = 1'b1;
                    m_cnt  = 0;
                end
            end
        end else if (out_ready) begin
            m_full = 1'b0;
            m_sat  = 1'b0;
        end
    end

    // Compare every cycle, on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < int'(N); i++) exp_op[i*W +: W] = m_slot[i];
        check("model in_ready", 128'(in_ready), 128'(!m_full));
        check("model out_valid", 128'(out_valid), 128'(m_full));
        check("model out_sat", 128'(out_sat), 128'(m_sat));
        check("model operand", operand, exp_op);
        check("model tmr_err", 128'(tmr_err), 128'(exp_tmr));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [15:0] x, input logic [15:0] w);
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [15:0] ux [8];
    logic [15:0] uw [8];
    logic [15:0] fx [8];

    initial begin
        clk = 1'b0; rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_x = '0; in_w = '0; out_ready = 1'b0;

        ux = '{16'h0400, 16'h8400, 16'h8000, 16'h0001, 16'h0001, 16'h8001, 16'h0400, 16'h8400};
        uw = '{16'h04d7, 16'h0200, 16'h0400, 16'h0200, 16'h01FF, 16'h0200, 16'h0400, 16'h8400};
        fx = '{16'h020a, 16'h0040, 16'h801b, 16'h81cc, 16'h83e1, 16'h04d7, 16'h0031, 16'h007a};

        // Reset state
        #1;
        check("reset operand", operand, 128'h0);
        check("reset out_valid", 128'(out_valid), 128'h0);
        check("reset out_sat", 128'(out_sat), 128'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("reset in_ready", 128'(in_ready), 128'h1);

        // Unit products and rounding
        for (int i = 0; i < 8; i++) send(ux[i], uw[i]);
        check("unit latency out_valid", 128'(out_valid), 128'h1);
        check("unit operand", operand, 128'h0400_0400_8001_0000_0001_0000_8200_04d7);
        handshake();
        check("unit after handshake", 128'(out_valid), 128'h0);

        // Full vector
        for (int i = 0; i < 8; i++) send(fx[i], 16'h0400);
        check("full operand", operand, 128'h007a_0031_04d7_83e1_81cc_801b_0040_020a);
        check("full out_sat", 128'(out_sat), 128'h0);
        handshake();

        // Saturation under backpressure
        send(16'h7c00, 16'h7c00);
        for (int i = 1; i < 8; i++) send(16'h0400, 16'h0400);
        for (int c = 0; c < 5; c++) begin
            check("sat in_ready", 128'(in_ready), 128'h0);
            check("sat out_sat", 128'(out_sat), 128'h1);
            check("sat operand", operand, 128'h0400_0400_0400_0400_0400_0400_0400_7fff);
            @(posedge clk);
            #1;
        end
        handshake();
        check("sat cleared", 128'(out_sat), 128'h0);
        for (int i = 0; i < 8; i++) send(fx[i], 16'h0400);
        check("next vector out_sat", 128'(out_sat), 128'h0);
        handshake();

        // Clear during fill drops the coincident pair
        for (int i = 0; i < 3; i++) send(16'h0800, 16'h0400);
        clear = 1'b1; in_valid = 1'b1; in_x = 16'h1000; in_w = 16'h0400;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) send(16'((i + 1) * 256), 16'h0400);
        check("clear operand", operand, 128'h0800_0700_0600_0500_0400_0300_0200_0100);

        // Clear while full discards the vector without a handshake
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear full out_valid", 128'(out_valid), 128'h0);
        check("clear full in_ready", 128'(in_ready), 128'h1);

        // Reset mid-fill
        for (int i = 0; i < 5; i++) send(16'h8c00, 16'h0400);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset operand", operand, 128'h0);
        check("midreset out_valid", 128'(out_valid), 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(fx[i], 16'h0400);
`ifdef TMR_CTRL_EN
            if (i == 2) begin
                dut.ctrl_q[1][1] = ~dut.ctrl_q[1][1];
                exp_tmr = 1'b1;
            end
            if (i == 3) exp_tmr = 1'b0;
`endif
        end
        check("postreset operand", operand, 128'h007a_0031_04d7_83e1_81cc_801b_0040_020a);
        check("postreset out_valid", 128'(out_valid), 128'h1);
        handshake();
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
